uart_rx: RTL and testbench
==========================

# uart_rx

UART receive driver with a runtime-configurable baud rate. It is the receive end of the link whose transmit end is `UART_TX`. It oversamples the serial input with the system clock, mid-bit samples one 8N1 frame (start, 8 data bits LSB first, stop), and presents the byte with a ready/clear handshake. It sits next to `UART_TX` in the CPU's UART peripheral and shares the same `baud_DB` divisor register.

## Interface
Parameters:
- `DATA_W`, default 8: data bits per frame. Only 8 is supported.
- `BAUD_W`, default 13: width of the divisor.

Ports, clock and reset first:
- `clk`, input, 1: global clock. This is the block's one clock.
- `rst`, input, 1: reset. Synchronous and active-high.
- `RX`, input, 1: serial input. Asynchronous to `clk`; idles high.
- `baud_DB`, input, BAUD_W: divisor. The bit period P is baud_DB+1 clocks, the same as `UART_TX`.
- `clr_rdy`, input, 1: consumer acknowledge. Clears `rdy`.
- `rx_data`, output, 8: last good received byte. Reset value 0x00.
- `rdy`, output, 1: `rx_data` holds an unread byte. Reset value 0.
- `rx_busy`, output, 1: a frame is in progress (any state other than IDLE). Reset value 0.
- `frm_err`, output, 1: one-cycle pulse when the stop bit samples 0. Reset value 0.
- `ovr_err`, output, 1: one-cycle pulse when a good frame completes while `rdy` is already 1. Reset value 0.

## Operation
- Synchronizer: two flops `rx_ff1` → `rx_s`, plus a history flop `rx_q`. All three reset to 1.
- Start condition: a falling edge, defined as `rx_s`=0 and `rx_q`=1, seen while in IDLE.
- Baud latch: `baud_DB` is captured into `stored_baud` when the start condition is seen. A change to `baud_DB` mid-frame has no effect on the current frame.
- Baud counter: down-counter, BAUD_W bits.
  - On the start condition it loads `baud_DB>>1` (floor).
  - After every sample it reloads `stored_baud`.
  - It decrements every cycle outside IDLE.
  - `sample` = counter == 0.
- States:
  - IDLE: waits for the start condition. On it, loads the counter and goes to START.
  - START: on `sample`, if `rx_s`=1 this is a false start, so return to IDLE with no outputs. Otherwise go to DATA with `bit_cnt` = 0.
  - DATA: on each `sample`, shift `rx_s` into the MSB of a shift register, so the first bit ends up in the LSB. After the 8th sample (`bit_cnt`==7) go to STOP.
  - STOP: on `sample`, return to IDLE and take one of two branches:
    - `rx_s`=1 (good frame): load `rx_data` from the shift register and set `rdy`=1. If `rdy` was already 1, also pulse `ovr_err` and overwrite `rx_data`.
    - `rx_s`=0 (framing error): pulse `frm_err`. Leave `rx_data` and `rdy` unchanged.
- `rdy` update rule:
  - `clr_rdy` clears `rdy` on the next edge.
  - If a good-frame completion lands in the same cycle as `clr_rdy`, the completion wins and `rdy`=1.
  - `clr_rdy` while `rdy`=0 has no effect.
- Back-to-back frames: the block returns to IDLE at mid-stop-bit. A start edge that arrives immediately after the stop bit is therefore caught.
- Line held low after a framing error (break): no retrigger, because a new frame needs a fresh falling edge.
- Reset mid-frame: state goes to IDLE and every output returns to its reset value. The partial byte is discarded.

## Timing
- Pin-to-detect latency: a falling edge on `RX` before clock edge n is seen as the start condition in the cycle after edge n+1.
- First (start) sample: (baud_DB>>1)+1 clocks after the start condition is registered.
- Later samples: spaced exactly P clocks apart.
- Frame completion: `rdy`, `frm_err` and `ovr_err` change on the clock edge after the stop sample.
  - That is 9·P + (baud_DB>>1) + 1 clocks after the start condition, plus the 2-cycle synchronizer delay, relative to the `RX` falling edge.
- Tolerance: with P ≥ 16, a transmitter whose bit period is within ±4 % of P is received error-free.
- `rx_busy` timing: rises the cycle after the start condition and falls on the edge that returns the block to IDLE.

## Structure
- Shared package `uart_pkg`, used by both `UART_TX` and `uart_rx`:
  - `BAUD_W` = 13.
  - `DATA_W` = 8.
  - `rx_state_t` enum {IDLE, START, DATA, STOP}.
- Sub-module `uart_sync2`: two-flop synchronizer with a reset value of 1, instantiated for `RX`.
- Everything else (counter, bit counter, shift register, FSM, output flags) lives in `uart_rx`.

## Test plan
1. Good byte, baud_DB=15 (P=16): drive an ideal frame for 0xA5 → `rdy`=1 and `rx_data`=0xA5 about 152 clocks after the start edge; `frm_err` and `ovr_err` stay 0.
2. Consume and back-to-back: pulse `clr_rdy`, then send 0x00 and 0xFF with no idle gap → `rdy` clears, then each byte is received in turn; `ovr_err` pulses on the second byte only if `clr_rdy` was not issued between the two frames.
3. False start: a 4-clock low glitch on `RX` at P=16 → `rx_busy` returns to 0 within 9 clocks; `rdy`, `rx_data` and the flags are unchanged.
4. Framing error: send 0x3C with the stop bit held 0, then keep the line low for 3·P → exactly one `frm_err` pulse; `rdy` stays 0; no retrigger until `RX` rises and falls again.
5. Baud change and skew: change `baud_DB` 15→31 mid-frame, and separately send a frame at P=16 with a +4 % skew (bit period ≈ 16.64 clocks) → the in-flight byte is correct at P=16; the skewed frame is correct; the next frame uses P=32.
6. Reset and corner cases:
   - Assert `rst` during data bit 4 → all outputs return to 0 and the state is IDLE; the following frame 0x5A is received correctly.
   - Assert `clr_rdy` in the same cycle as a completion → `rdy`=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripheral: divisor width, frame width and
// the receiver state encoding used by uart_rx.
package uart_pkg;

    localparam int BAUD_W = 13;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input; both stages reset to 1 so
// an idle-high serial line produces no spurious edge after reset.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta_ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_ff  <= 1'b1;
            sync_out <= 1'b1;
        end else begin
            meta_ff  <= async_in;
            sync_out <= meta_ff;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes RX, mid-bit samples one frame using a
// divisor latched at the start edge, and hands the byte over via rdy/clr_rdy.
module uart_rx #(
    parameter int DATA_W = uart_pkg::DATA_W,
    parameter int BAUD_W = uart_pkg::BAUD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RX,
    input  logic [BAUD_W-1:0] baud_DB,
    input  logic              clr_rdy,
    output logic [DATA_W-1:0] rx_data,
    output logic              rdy,
    output logic              rx_busy,
    output logic              frm_err,
    output logic              ovr_err
);

    import uart_pkg::*;

    rx_state_t         state;
    logic              rx_s;
    logic              rx_q;
    logic              sample;
    logic              start_cond;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] stored_baud;
    logic [2:0]        bit_cnt;
    logic [DATA_W-1:0] shift_reg;

    uart_sync2 u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_in(RX),
        .sync_out(rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q <= 1'b1;
        end else begin
            rx_q <= rx_s;
        end
    end

    assign sample     = (baud_cnt == '0);
    assign start_cond = ~rx_s & rx_q;

    // Half-period first load centres every later sample in its bit cell.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            stored_baud <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            rx_data     <= '0;
            rdy         <= 1'b0;
            rx_busy     <= 1'b0;
            frm_err     <= 1'b0;
            ovr_err     <= 1'b0;
        end else begin
            frm_err <= 1'b0;
            ovr_err <= 1'b0;

            if (clr_rdy) begin
                rdy <= 1'b0;
            end

            if (state != IDLE) begin
                baud_cnt <= sample ? stored_baud : baud_cnt - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_cond) begin
                        stored_baud <= baud_DB;
                        baud_cnt    <= baud_DB >> 1;
                        rx_busy     <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    if (sample) begin
                        if (rx_s) begin
                            rx_busy <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= '0;
                            state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (sample) begin
                        shift_reg <= {rx_s, shift_reg[DATA_W-1:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'(DATA_W - 1)) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (sample) begin
                        rx_busy <= 1'b0;
                        state   <= IDLE;
                        // A completing frame overrides a same-cycle clr_rdy.
                        if (rx_s) begin
                            rx_data <= shift_reg;
                            rdy     <= 1'b1;
                            ovr_err <= rdy;
                        end else begin
                            frm_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    rx_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: ideal, skewed, erroneous and interrupted frames
// driven on RX with time delays; clock period 100 units, so P=16 is 1600.
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [12:0] baud_DB;
    logic        clr_rdy;
    logic [7:0]  rx_data;
    logic        rdy;
    logic        rx_busy;
    logic        frm_err;
    logic        ovr_err;

    int testsRun    = 0;
    int testsFailed = 0;
    int frmCount    = 0;
    int ovrCount    = 0;
    int frmBase;
    int ovrBase;
    int lat;
    bit seen;

    uart_rx dut (
        .clk    (clk),
        .rst    (rst),
        .RX     (rx),
        .baud_DB(baud_DB),
        .clr_rdy(clr_rdy),
        .rx_data(rx_data),
        .rdy    (rdy),
        .rx_busy(rx_busy),
        .frm_err(frm_err),
        .ovr_err(ovr_err)
    );

    always #50 clk = ~clk;

    always @(posedge clk) begin
        if (frm_err) frmCount <= frmCount + 1;
        if (ovr_err) ovrCount <= ovrCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one frame; the line is left at the stop-bit level afterwards.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                 input int bitUnits);
        rx = 1'b0;
        #(bitUnits);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            #(bitUnits);
        end
        rx = stopBit;
        #(bitUnits);
    endtask

    task automatic pulseClear();
        @(negedge clk) clr_rdy = 1'b1;
        @(negedge clk) clr_rdy = 1'b0;
    endtask

    task automatic waitRdy();
        lat = 0;
        while (!rdy && lat < 400) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #10_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst     = 1'b1;
        rx      = 1'b1;
        clr_rdy = 1'b0;
        baud_DB = 13'd15;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rdy",     {31'd0, rdy},     32'd0);
        checkOutput("reset_rx_data", {24'd0, rx_data}, 32'd0);
        checkOutput("reset_busy",    {31'd0, rx_busy}, 32'd0);
        checkOutput("reset_frm",     {31'd0, frm_err}, 32'd0);
        checkOutput("reset_ovr",     {31'd0, ovr_err}, 32'd0);
        rst = 1'b0;
        #1000;

        // Good byte, latency measured from the falling edge to rdy.
        @(negedge clk);
        fork
            applyStimulus(8'hA5, 1'b1, 1600);
            waitRdy();
        join
        checkOutput("t1_latency_ok", {31'd0, (lat >= 152 && lat <= 157)}, 32'd1);
        checkOutput("t1_data", {24'd0, rx_data}, 32'hA5);
        checkOutput("t1_rdy",  {31'd0, rdy}, 32'd1);
        checkOutput("t1_frm",  frmCount, 32'd0);
        checkOutput("t1_ovr",  ovrCount, 32'd0);

        // Consume, then back-to-back frames without and with a clear between.
        pulseClear();
        checkOutput("t2_rdy_cleared", {31'd0, rdy}, 32'd0);
        ovrBase = ovrCount;
        @(negedge clk);
        fork
            begin
                applyStimulus(8'h00, 1'b1, 1600);
                applyStimulus(8'hFF, 1'b1, 1600);
            end
            begin
                waitRdy();
                checkOutput("t2_first_byte", {24'd0, rx_data}, 32'h00);
            end
        join
        #1000;
        checkOutput("t2_second_byte", {24'd0, rx_data}, 32'hFF);
        checkOutput("t2_ovr_pulse", ovrCount - ovrBase, 32'd1);
        checkOutput("t2_frm", frmCount, 32'd0);

        pulseClear();
        ovrBase = ovrCount;
        @(negedge clk);
        fork
            begin
                applyStimulus(8'h12, 1'b1, 1600);
                applyStimulus(8'h34, 1'b1, 1600);
            end
            begin
                waitRdy();
                checkOutput("t2b_first_byte", {24'd0, rx_data}, 32'h12);
                pulseClear();
            end
        join
        #1000;
        checkOutput("t2b_second_byte", {24'd0, rx_data}, 32'h34);
        checkOutput("t2b_no_ovr", ovrCount - ovrBase, 32'd0);

        // False start: 4-clock low glitch.
        frmBase = frmCount;
        ovrBase = ovrCount;
        @(negedge clk) rx = 1'b0;
        #400 rx = 1'b1;
        @(negedge clk);
        checkOutput("t3_busy_rises", {31'd0, rx_busy}, 32'd1);
        repeat (9) @(negedge clk);
        checkOutput("t3_busy_falls", {31'd0, rx_busy}, 32'd0);
        checkOutput("t3_rdy",  {31'd0, rdy}, 32'd1);
        checkOutput("t3_data", {24'd0, rx_data}, 32'h34);
        checkOutput("t3_flags", (frmCount - frmBase) + (ovrCount - ovrBase), 32'd0);
        #2000;

        // Framing error followed by a held-low line.
        pulseClear();
        frmBase = frmCount;
        @(negedge clk);
        applyStimulus(8'h3C, 1'b0, 1600);
        #(3 * 1600);
        checkOutput("t4_frm_once", frmCount - frmBase, 32'd1);
        checkOutput("t4_rdy",      {31'd0, rdy}, 32'd0);
        checkOutput("t4_no_retrig", {31'd0, rx_busy}, 32'd0);
        checkOutput("t4_data_kept", {24'd0, rx_data}, 32'h34);
        rx = 1'b1;
        #1600;
        @(negedge clk);
        applyStimulus(8'h69, 1'b1, 1600);
        #1000;
        checkOutput("t4_recover", {24'd0, rx_data}, 32'h69);

        // +4% skewed frame, then a divisor change in flight, then P=32.
        frmBase = frmCount;
        @(negedge clk);
        applyStimulus(8'hC5, 1'b1, 1664);
        #1000;
        checkOutput("t5_skew", {24'd0, rx_data}, 32'hC5);
        @(negedge clk);
        fork
            applyStimulus(8'h96, 1'b1, 1600);
            begin
                #5000 baud_DB = 13'd31;
            end
        join
        #1000;
        checkOutput("t5_inflight", {24'd0, rx_data}, 32'h96);
        @(negedge clk);
        applyStimulus(8'hE7, 1'b1, 3200);
        #2000;
        checkOutput("t5_p32", {24'd0, rx_data}, 32'hE7);
        checkOutput("t5_frm", frmCount - frmBase, 32'd0);
        baud_DB = 13'd15;
        #1000;

        // Reset during data bit 4 (line high from there on).
        @(negedge clk);
        fork
            applyStimulus(8'hF0, 1'b1, 1600);
            begin
                #(1600 * 5 + 800) rst = 1'b1;
                @(negedge clk);
                @(negedge clk);
                checkOutput("t6_rst_rdy",  {31'd0, rdy}, 32'd0);
                checkOutput("t6_rst_data", {24'd0, rx_data}, 32'd0);
                checkOutput("t6_rst_busy", {31'd0, rx_busy}, 32'd0);
                rst = 1'b0;
            end
        join
        #1000;
        checkOutput("t6_after_rst_idle", {30'd0, rx_busy, rdy}, 32'd0);
        @(negedge clk);
        applyStimulus(8'h5A, 1'b1, 1600);
        #1000;
        checkOutput("t6_5a", {24'd0, rx_data}, 32'h5A);
        checkOutput("t6_5a_rdy", {31'd0, rdy}, 32'd1);

        // clr_rdy held high across a completion: completion must win once.
        ovrBase = ovrCount;
        @(negedge clk) clr_rdy = 1'b1;
        seen = 1'b0;
        fork
            applyStimulus(8'h81, 1'b1, 1600);
            begin
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (rdy) seen = 1'b1;
                end
            end
        join
        clr_rdy = 1'b0;
        checkOutput("t6_clr_collide", {31'd0, seen}, 32'd1);
        checkOutput("t6_clr_data", {24'd0, rx_data}, 32'h81);
        checkOutput("t6_clr_after", {31'd0, rdy}, 32'd0);
        checkOutput("t6_clr_no_ovr", ovrCount - ovrBase, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
